// File: rtl/imm_encoder_if.sv
// Handshake bundle for imm_encoder: input transaction, output transaction and error signals.
// ErrCount exists only when IMM_ENC_ERRCNT_EN is defined.
interface imm_encoder_if
`ifdef IMM_ENC_ERRCNT_EN
   #(parameter int unsigned ERR_CNT_W = 8)
`endif
   ;
   logic        InValid;
   logic        InReady;
   logic [1:0]  ImmSrc;
   logic [31:0] Imm;
   logic [31:0] BaseInstr;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] Instr;
   logic        ImmErr;
   logic        ErrPulse;
`ifdef IMM_ENC_ERRCNT_EN
   logic [ERR_CNT_W-1:0] ErrCount;
`endif

   modport master (
      output InValid, ImmSrc, Imm, BaseInstr, OutReady,
      input  InReady, OutValid, Instr, ImmErr, ErrPulse
`ifdef IMM_ENC_ERRCNT_EN
      , input ErrCount
`endif
   );

   modport slave (
      input  InValid, ImmSrc, Imm, BaseInstr, OutReady,
      output InReady, OutValid, Instr, ImmErr, ErrPulse
`ifdef IMM_ENC_ERRCNT_EN
      , output ErrCount
`endif
   );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage immediate packer: stage 1 range-checks, stage 2 holds the packed I/S/B/J instruction.
// Optional saturating error counter enabled by IMM_ENC_ERRCNT_EN.
module imm_encoder #(
   parameter int unsigned DROP_ON_ERR = 0,
   parameter int unsigned ERR_CNT_W   = 8
) (
   input logic          clk,
   input logic          reset,
   imm_encoder_if.slave bus
);

   localparam bit DropOnErr = (DROP_ON_ERR != 0);

   if (ERR_CNT_W < 1) begin : g_bad_cnt_w
      $error("ERR_CNT_W must be at least 1");
   end

   logic        s1_valid_q;
   logic [1:0]  s1_src_q;
   logic [31:0] s1_imm_q;
   logic [31:0] s1_base_q;
   logic        s2_valid_q;
   logic [31:0] s2_instr_q;
   logic        s2_err_q;
   logic        err_pulse_q;

   logic        legal;
   logic [31:0] packed_instr;
   logic        s2_load;
   logic        s1_adv;
   logic        s2_keep;
   logic        in_ready;
   logic        in_fire;
   logic        sext_ok_11;
   logic        sext_ok_12;
   logic        sext_ok_20;

   // Upper bits must be a pure sign extension of the field's top bit.
   assign sext_ok_11 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
   assign sext_ok_12 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
   assign sext_ok_20 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

   always_comb begin
      legal        = 1'b0;
      packed_instr = s1_base_q;
      case (s1_src_q)
         2'b00: begin
            legal               = sext_ok_11;
            packed_instr[31:20] = s1_imm_q[11:0];
         end
         2'b01: begin
            legal               = sext_ok_11;
            packed_instr[31:25] = s1_imm_q[11:5];
            packed_instr[11:7]  = s1_imm_q[4:0];
         end
         2'b10: begin
            legal               = sext_ok_12 & ~s1_imm_q[0];
            packed_instr[31]    = s1_imm_q[12];
            packed_instr[7]     = s1_imm_q[11];
            packed_instr[30:25] = s1_imm_q[10:5];
            packed_instr[11:8]  = s1_imm_q[4:1];
         end
         default: begin
            legal               = sext_ok_20 & ~s1_imm_q[0];
            packed_instr[31]    = s1_imm_q[20];
            packed_instr[19:12] = s1_imm_q[19:12];
            packed_instr[20]    = s1_imm_q[11];
            packed_instr[30:21] = s1_imm_q[10:1];
         end
      endcase
   end

   always_comb begin
      s2_load  = ~s2_valid_q | bus.OutReady;
      s1_adv   = s1_valid_q & s2_load;
      // In drop mode an illegal entry leaves stage 1 but leaves a bubble behind.
      s2_keep  = s1_adv & (~DropOnErr | legal);
      in_ready = ~s1_valid_q | s2_load;
      in_fire  = bus.InValid & in_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_src_q    <= 2'b00;
         s1_imm_q    <= '0;
         s1_base_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_instr_q  <= '0;
         s2_err_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_src_q   <= bus.ImmSrc;
            s1_imm_q   <= bus.Imm;
            s1_base_q  <= bus.BaseInstr;
         end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
         end
         if (s2_load) begin
            s2_valid_q <= s2_keep;
         end
         if (s2_keep) begin
            s2_instr_q <= packed_instr;
            s2_err_q   <= ~legal;
         end
         err_pulse_q <= s1_adv & ~legal;
      end
   end

   assign bus.InReady  = in_ready;
   assign bus.OutValid = s2_valid_q;
   assign bus.Instr    = s2_instr_q;
   assign bus.ImmErr   = s2_err_q;
   assign bus.ErrPulse = err_pulse_q;

`ifdef IMM_ENC_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (s1_adv && !legal && !(&err_cnt_q)) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
   end

   assign bus.ErrCount = err_cnt_q;
`endif

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate sign-extension decoder. Takes a 32-bit immediate, an ImmSrc selector and a base instruction word.
- Packs the immediate into the I/S/B/J bit positions of the base word and produces the finished 32-bit instruction.
- Flags immediates that cannot be represented in the selected format.
- Used by the self-test instruction generator and the assembler-side testbench. Two-stage valid/ready pipeline with throughput of 1 per cycle.

Parameters:
- DROP_ON_ERR, 0: 1 = an illegal transaction is consumed and pulses ErrPulse but never appears at the output; 0 = it is passed through with ImmErr=1.
- ERR_CNT_W, 8: width of the error counter (used only with IMM_ENC_ERRCNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  input transaction valid.
- InReady  out  1  encoder can accept this cycle.
- ImmSrc  in  2  format: 00 I, 01 S, 10 B, 11 J.
- Imm  in  32  signed immediate (byte offset for B/J).
- BaseInstr  in  32  supplies opcode/rd/rs/funct bits; its immediate-field bits are ignored.
- OutValid  out  1  output transaction valid.
- OutReady  in  1  downstream accepts.
- Instr  out  32  encoded instruction.
- ImmErr  out  1  immediate was not representable (qualified by OutValid).
- ErrPulse  out  1  one-cycle pulse when an illegal transaction leaves stage 1.
- ErrCount  out  ERR_CNT_W  saturating error count (macro only).

Behaviour:
- Reset (async, immediate):
  - Both stage valids = 0, so OutValid=0.
  - Instr=0, ImmErr=0, ErrPulse=0, ErrCount=0.
  - InReady=1 on the first clock after reset deasserts.
- Handshake:
  - A transfer occurs when Valid && Ready on a rising edge.
  - Once OutValid is high, Instr/ImmErr hold stable until OutReady.
  - OutValid never drops without a transfer.
- Stage 1 (check):
  - Registers ImmSrc, Imm, BaseInstr on an input transfer.
  - Computes legal from the registered values:
    - I/S: Imm[31:11] all equal.
    - B: Imm[31:12] all equal and Imm[0]=0.
    - J: Imm[31:20] all equal and Imm[0]=0.
- Stage 2 (pack). Start from BaseInstr and overwrite the immediate field:
  - I: [31:20]=Imm[11:0].
  - S: [31:25]=Imm[11:5], [11:7]=Imm[4:0].
  - B: [31]=Imm[12], [7]=Imm[11], [30:25]=Imm[10:5], [11:8]=Imm[4:1].
  - J: [31]=Imm[20], [19:12]=Imm[19:12], [20]=Imm[11], [30:21]=Imm[10:1].
  - All other bits come from BaseInstr.
  - Out-of-range immediates are truncated the same way; ImmErr=!legal.
- Flow control:
  - Stage 2 loads when it is empty or OutReady=1.
  - Stage 1 advances when stage 2 loads.
  - InReady = !S1valid || stage-1 advancing (a combinational path from OutReady is permitted).
  - Latency is 2 clocks from input transfer to OutValid with no stall.
  - Simultaneous input and output transfer sustains 1/cycle.
- DROP_ON_ERR=1:
  - An illegal stage-1 entry advances into a bubble: stage 2 is not loaded.
  - It still requires stage-1 advance conditions.
  - ImmErr is then always 0 at the output.
- ErrPulse: high for exactly one cycle when an illegal entry leaves stage 1, in either mode.
- Round-trip guarantee: when ImmErr=0, feeding Instr[31:7] and the same ImmSrc to the sign-extension decoder yields Imm exactly.
- Boundary cases:
  - Full pipeline with OutReady=0: InReady=0, and no data may be lost or duplicated.
  - Reset mid-stream discards both stages; nothing is emitted afterwards.

Optional Feature:
- Macro IMM_ENC_ERRCNT_EN.
- Defined:
  - ErrCount increments on each ErrPulse and saturates at all-ones.
  - Cleared only by reset.
- Undefined: the ErrCount port is absent and no counter logic is built.

Test Plan:
- I-type: Imm=0xFFFFF800 (-2048), BaseInstr=0x00000013, OutReady=1 -> Instr=0x80000013, ImmErr=0, OutValid exactly 2 cycles after the transfer.
- B-type: Imm=0xFFFFFFFC (-4), BaseInstr=0x00000063 -> Instr=0xFE000EE3, ImmErr=0.
- J-type illegal: Imm=0x00100000 -> ImmErr=1 and ErrPulse for one cycle; with DROP_ON_ERR=1 no OutValid is produced, and ErrCount=1 under the macro.
- Misaligned: B with Imm=0x00000006 is legal; B with Imm=0x00000003 gives ImmErr=1.
- Backpressure: stream 8 random legal S-type words with OutReady toggling 50% -> output matches the input sequence in order; InReady=0 whenever both stages are full and OutReady=0.
- Reset mid-operation: assert reset with 2 entries in flight -> OutValid=0 immediately; after release, a new word emerges after 2 cycles with no stale data.
